// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin, packet-atomic sharing of one UART transmitter |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WORD_SIZE = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                       a_clk,
  input  logic                       a_rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WORD_SIZE-1:0] req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [WORD_SIZE-1:0]       tx_byte,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [N_REQ-1:0]           grant_o,
  output logic                       timeout_o
);

  localparam int          c_IDX_W   = $clog2(N_REQ);
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ACCEPT    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [c_IDX_W-1:0]     r_ptr;
  logic [c_IDX_W-1:0]     r_gidx;
  logic [N_REQ-1:0]       r_grant;
  logic [WORD_SIZE-1:0]   r_tx_byte;
  logic                   r_last;
  logic [15:0]            r_cnt;

  logic [c_IDX_W-1:0]     w_cand;
  logic [c_IDX_W-1:0]     w_sel_idx;
  logic [N_REQ-1:0]       w_sel_onehot;
  logic                   w_gvalid;
  logic [WORD_SIZE-1:0]   w_gdata;
  logic [N_REQ-1:0]       w_ready;
  logic                   w_start;
  logic                   w_timeout;
  logic                   w_accept;
  logic                   w_grant_set;
  logic                   w_release;

  // Scan from farthest to nearest so the first valid index after r_ptr wins.
  always_comb begin
    w_cand    = '0;
    w_sel_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = c_IDX_W'((32'(r_ptr) + 32'(k)) % N_REQ);
      if (req_valid[w_cand]) begin
        w_sel_idx = w_cand;
      end
    end
  end

  assign w_sel_onehot = N_REQ'(1) << w_sel_idx;
  assign w_gvalid     = req_valid[r_gidx];
  assign w_gdata      = req_data[r_gidx*WORD_SIZE +: WORD_SIZE];

  always_comb begin
    w_next      = r_state;
    w_ready     = '0;
    w_start     = 1'b0;
    w_timeout   = 1'b0;
    w_accept    = 1'b0;
    w_grant_set = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid && !tx_busy) begin
          w_grant_set = 1'b1;
          w_next      = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        w_ready  = r_grant;
        w_accept = 1'b1;
        w_next   = S_START;
      end
      S_START: begin
        w_start = 1'b1;
        w_next  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_cnt == c_TIMEOUT) begin
          w_timeout = 1'b1;
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_last) begin
            w_release = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A byte arriving on the timeout cycle still wins.
        if (w_gvalid) begin
          w_ready  = r_grant;
          w_accept = 1'b1;
          w_next   = S_START;
        end else if (r_cnt == c_TIMEOUT) begin
          w_timeout = 1'b1;
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= c_IDX_W'(N_REQ - 1);
      r_gidx    <= '0;
      r_grant   <= '0;
      r_tx_byte <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_set) begin
        r_grant <= w_sel_onehot;
        r_gidx  <= w_sel_idx;
      end else if (w_release) begin
        r_grant <= '0;
        r_ptr   <= r_gidx;
      end
      if (w_accept) begin
        r_tx_byte <= w_gdata;
        r_last    <= req_last[r_gidx];
      end
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_BUSY || r_state == S_HOLD) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign req_ready = w_ready;
  assign tx_start  = w_start;
  assign timeout_o = w_timeout;
  assign tx_byte   = r_tx_byte;
  assign grant_o   = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int c_N  = 4;
  localparam int c_W  = 8;
  localparam int c_TO = 20;

  logic               a_clk = 1'b0;
  logic               a_rst;
  logic [c_N-1:0]     req_valid;
  logic [c_N*c_W-1:0] req_data;
  logic [c_N-1:0]     req_last;
  logic [c_N-1:0]     req_ready;
  logic [c_W-1:0]     tx_byte;
  logic               tx_start;
  logic               tx_busy;
  logic [c_N-1:0]     grant_o;
  logic               timeout_o;

  uart_tx_arbiter #(.N_REQ(c_N), .WORD_SIZE(c_W), .TIMEOUT(c_TO)) u_dut (
    .a_clk     (a_clk),
    .a_rst     (a_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_byte   (tx_byte),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  always #5 a_clk = ~a_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Requester byte queues: {last, data}
  logic [8:0] rmem [c_N][16];
  int         rhead [c_N];
  int         rtail [c_N];
  logic       stuck_tx;
  int         busy_left;

  task automatic push(input int i, input logic last, input logic [7:0] d);
    rmem[i][rtail[i] % 16] = {last, d};
    rtail[i]++;
  endtask

  function automatic logic q_empty();
    logic e;
    e = 1'b1;
    for (int i = 0; i < c_N; i++) if (rhead[i] != rtail[i]) e = 1'b0;
    return e;
  endfunction

  // Requester and transmitter models
  initial begin
    logic [c_N-1:0] rdy;
    logic           start_seen;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    busy_left = 0;
    for (int i = 0; i < c_N; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    forever begin
      @(negedge a_clk);
      rdy        = req_ready;
      start_seen = tx_start;
      @(posedge a_clk);
      #1;
      for (int i = 0; i < c_N; i++) begin
        if (rdy[i]) rhead[i]++;
        req_valid[i]           = (rhead[i] != rtail[i]);
        req_data[i*c_W +: c_W] = rmem[i][rhead[i] % 16][7:0];
        req_last[i]            = rmem[i][rhead[i] % 16][8];
      end
      if (busy_left > 0) busy_left--;
      if (start_seen && !stuck_tx) busy_left = 10;
      tx_busy = (busy_left > 0);
    end
  end

  // Cycle counter, tx_start log and invariant monitor
  int         cyc = 0;
  int         log_n = 0;
  logic [7:0] log_b [64];
  int         log_g [64];
  int         log_c [64];
  int         inv_err = 0;

  function automatic int oh2idx(input logic [c_N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < c_N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial forever begin
    @(posedge a_clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge a_clk);
    if (tx_start && log_n < 64) begin
      log_b[log_n] = tx_byte;
      log_g[log_n] = oh2idx(grant_o);
      log_c[log_n] = cyc;
      log_n        = log_n + 1;
    end
    if (!a_rst) begin
      if ((grant_o & (grant_o - 1'b1)) != '0) inv_err++;
      if (req_ready != '0 && req_ready != grant_o) inv_err++;
      if (tx_start && tx_busy) inv_err++;
    end
  end

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    repeat (2) @(negedge a_clk);
    while (!(grant_o == '0 && !tx_busy && req_valid == '0 && q_empty()) && k < 400) begin
      @(negedge a_clk);
      k++;
    end
    chk({tag, "_idle_bound"}, 32'(k < 400), 32'd1);
  endtask

  task automatic wait_sig(input string tag, input int which);
    int k;
    k = 0;
    @(negedge a_clk);
    while (!(which == 0 ? tx_start : timeout_o) && k < 100) begin
      @(negedge a_clk);
      k++;
    end
    chk({tag, "_wait_bound"}, 32'(k < 100), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int t;
    int bad;
    int k;
    a_rst    = 1'b1;
    stuck_tx = 1'b0;
    repeat (2) @(posedge a_clk);
    @(negedge a_clk);
    chk("rst_grant", grant_o, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_timeout", timeout_o, 0);
    a_rst = 1'b0;

    // Single byte
    nb = log_n;
    push(0, 1'b1, 8'h55);
    @(posedge a_clk);
    @(negedge a_clk);
    chk("t1_ready_c0", req_ready, 4'b0000);
    @(negedge a_clk);
    chk("t1_ready_c1", req_ready, 4'b0001);
    chk("t1_grant_c1", grant_o, 4'b0001);
    @(negedge a_clk);
    chk("t1_start_c2", tx_start, 1);
    chk("t1_byte_c2", tx_byte, 8'h55);
    wait_idle("t1");
    chk("t1_count", log_n - nb, 1);

    // Packet atomicity
    nb = log_n;
    push(1, 1'b0, 8'hA1);
    push(1, 1'b0, 8'hA2);
    push(1, 1'b1, 8'hA3);
    push(2, 1'b1, 8'hB1);
    wait_idle("t2");
    chk("t2_b0", log_b[nb],   8'hA1);
    chk("t2_b1", log_b[nb+1], 8'hA2);
    chk("t2_b2", log_b[nb+2], 8'hA3);
    chk("t2_b3", log_b[nb+3], 8'hB1);
    chk("t2_g2", log_g[nb+2], 1);
    chk("t2_g3", log_g[nb+3], 2);
    chk("t2_gap_hold", log_c[nb+1] - log_c[nb], 13);
    chk("t2_gap_pkt", log_c[nb+3] - log_c[nb+2], 14);

    // Round-robin from a fresh reset
    a_rst = 1'b1;
    @(negedge a_clk);
    a_rst = 1'b0;
    nb = log_n;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < c_N; i++) push(i, 1'b1, 8'(i*16 + p));
    wait_idle("t3");
    for (int e = 0; e < 8; e++) begin
      chk($sformatf("t3_g%0d", e), log_g[nb+e], e % 4);
    end
    chk("t3_b5", log_b[nb+5], 8'h11);
    chk("t3_gap", log_c[nb+1] - log_c[nb], 14);

    // HOLD timeout
    nb = log_n;
    push(0, 1'b0, 8'h77);
    push(1, 1'b1, 8'h99);
    wait_sig("t4_to", 1);
    t = cyc;
    chk("t4_g0", log_g[nb], 0);
    chk("t4_to_delay", t - log_c[nb], 32);
    @(negedge a_clk);
    chk("t4_grant_drop", grant_o, 0);
    chk("t4_to_pulse", timeout_o, 0);
    @(negedge a_clk);
    chk("t4_grant_next", grant_o, 4'b0010);
    chk("t4_ready_next", req_ready, 4'b0010);
    wait_idle("t4");
    chk("t4_b1", log_b[nb+1], 8'h99);

    // Stuck transmitter
    nb = log_n;
    stuck_tx = 1'b1;
    push(2, 1'b1, 8'hC3);
    wait_sig("t5_to", 1);
    chk("t5_to_delay", cyc - log_c[nb], 21);
    @(negedge a_clk);
    chk("t5_grant_drop", grant_o, 0);
    stuck_tx = 1'b0;
    wait_idle("t5");

    // Reset mid-packet
    nb = log_n;
    push(3, 1'b1, 8'hE1);
    wait_sig("t6_start", 0);
    repeat (3) @(negedge a_clk);
    chk("t6_busy_pre", tx_busy, 1);
    a_rst = 1'b1;
    push(1, 1'b1, 8'h1B);
    push(0, 1'b1, 8'h0A);
    @(negedge a_clk);
    chk("t6_rst_grant", grant_o, 0);
    chk("t6_rst_byte", tx_byte, 0);
    chk("t6_rst_ready", req_ready, 0);
    a_rst = 1'b0;
    bad = 0;
    k   = 0;
    while (tx_busy && k < 30) begin
      if (grant_o != '0) bad++;
      @(negedge a_clk);
      k++;
    end
    chk("t6_nogrant_busy", bad, 0);
    @(negedge a_clk);
    chk("t6_grant_r0", grant_o, 4'b0001);
    wait_idle("t6");
    chk("t6_b1", log_b[nb+1], 8'h0A);
    chk("t6_b2", log_b[nb+2], 8'h1B);

    chk("invariants", inv_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
